// File: rtl/vdp1_pkg.sv
// Shared constants and FSM state type for the VDP1 framebuffer erase block.
package vdp1_pkg;

  localparam int unsigned FB_W_DEF = 352;
  localparam int unsigned FB_H_DEF = 256;
  localparam int unsigned FB_AW    = 17;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ERASE,
    DONE
  } erase_state_t;

endpackage

// File: rtl/vdp1_erase_addr_gen.sv
// Rectangle walker for the erase sequencer: x/y counters, row_base accumulator,
// clipped bounds, last-word and empty-rectangle flags.
module vdp1_erase_addr_gen
  import vdp1_pkg::*;
#(
  parameter int unsigned FB_W = FB_W_DEF,
  parameter int unsigned FB_H = FB_H_DEF,
  parameter int unsigned AW   = FB_AW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          advance,
  input  logic [5:0]    x1,
  input  logic [5:0]    x2,
  input  logic [8:0]    y1,
  input  logic [8:0]    y2,
  output logic [AW-1:0] addr,
  output logic          last,
  output logic          empty
);

  localparam logic [9:0] XMAX = 10'(FB_W - 1);
  localparam logic [8:0] YMAX = 9'(FB_H - 1);

  // Constant multiply by FB_W expanded into one shifted add per set bit of FB_W.
  function automatic logic [AW-1:0] times_fb_w(input logic [8:0] y);
    logic [AW-1:0] acc;
    logic [AW-1:0] yy;
    acc = '0;
    yy  = AW'(y);
    for (int i = 0; i < 32; i++) begin
      if (FB_W[i]) acc = acc + (yy << i);
    end
    return acc;
  endfunction

  logic [9:0]    xs_c, xe_raw, xe_c;
  logic [8:0]    ye_c;
  logic [9:0]    x_q, xs_q, xe_q;
  logic [8:0]    y_q, ye_q;
  logic [AW-1:0] row_q;

  always_comb begin
    xs_c   = {1'b0, x1, 3'b000};
    xe_raw = {1'b0, x2, 3'b111};
    xe_c   = (xe_raw > XMAX) ? XMAX : xe_raw;
    ye_c   = (y2 > YMAX) ? YMAX : y2;
    empty  = (x1 > x2) || (y1 > y2) || (xs_c > XMAX) || (y1 > YMAX);
    addr   = row_q + AW'(x_q);
    last   = (x_q == xe_q) && (y_q == ye_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      xs_q  <= '0;
      xe_q  <= '0;
      ye_q  <= '0;
      row_q <= '0;
    end else if (load) begin
      x_q   <= xs_c;
      y_q   <= y1;
      xs_q  <= xs_c;
      xe_q  <= xe_c;
      ye_q  <= ye_c;
      row_q <= times_fb_w(y1);
    end else if (advance) begin
      if (x_q == xe_q) begin
        x_q   <= xs_q;
        y_q   <= y_q + 9'd1;
        row_q <= row_q + AW'(FB_W);
      end else begin
        x_q <= x_q + 10'd1;
      end
    end
  end

endmodule

// File: rtl/vdp1_fb_erase.sv
// Framebuffer erase sequencer: fills an inclusive rectangle with one colour, one word
// per granted cycle. Define VDP1_ERASE_ABORT_EN to add the abort input.
module vdp1_fb_erase
  import vdp1_pkg::*;
#(
  parameter int unsigned FB_W = FB_W_DEF,
  parameter int unsigned FB_H = FB_H_DEF,
  parameter int unsigned AW   = FB_AW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [15:0]   erase_color,
  input  logic [5:0]    x1,
  input  logic [5:0]    x2,
  input  logic [8:0]    y1,
  input  logic [8:0]    y2,
  input  logic          stall,
`ifdef VDP1_ERASE_ABORT_EN
  input  logic          abort,
`endif
  output logic [AW-1:0] fb_addr,
  output logic [15:0]   fb_data,
  output logic [1:0]    fb_wren,
  output logic          busy,
  output logic          done
);

  erase_state_t  state;
  logic [15:0]   color_q;
  logic [5:0]    x1_q, x2_q;
  logic [8:0]    y1_q, y2_q;
  logic          load, advance, kill;
  logic [AW-1:0] gen_addr;
  logic          gen_last, gen_empty;

`ifdef VDP1_ERASE_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign load    = (state == SETUP);
  assign advance = (state == ERASE) && !stall && !kill;

  vdp1_erase_addr_gen #(
    .FB_W (FB_W),
    .FB_H (FB_H),
    .AW   (AW)
  ) u_addr_gen (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .x1      (x1_q),
    .x2      (x2_q),
    .y1      (y1_q),
    .y2      (y2_q),
    .addr    (gen_addr),
    .last    (gen_last),
    .empty   (gen_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      fb_addr <= '0;
      fb_data <= '0;
      fb_wren <= 2'b00;
      busy    <= 1'b0;
      done    <= 1'b0;
      color_q <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
    end else begin
      fb_wren <= 2'b00;
      done    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            color_q <= erase_color;
            x1_q    <= x1;
            x2_q    <= x2;
            y1_q    <= y1;
            y2_q    <= y2;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (kill || gen_empty) state <= DONE;
          else                   state <= ERASE;
        end
        ERASE: begin
          // Abort wins over both stall and a write pending this cycle.
          if (kill) begin
            state <= DONE;
          end else if (!stall) begin
            fb_addr <= gen_addr;
            fb_data <= color_q;
            fb_wren <= 2'b11;
            if (gen_last) state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp1_fb_erase.sv
// Scoreboard bench for vdp1_fb_erase: expected writes queued at start, popped per write.
module tb_vdp1_fb_erase;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] erase_color = '0;
  logic [5:0]  x1 = '0, x2 = '0;
  logic [8:0]  y1 = '0, y2 = '0;
  logic [16:0] fb_addr;
  logic [15:0] fb_data;
  logic [1:0]  fb_wren;
  logic        busy, done;
`ifdef VDP1_ERASE_ABORT_EN
  logic        abort = 1'b0;
`endif

  always #5 clock = ~clock;

  vdp1_fb_erase dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .erase_color (erase_color),
    .x1          (x1),
    .x2          (x2),
    .y1          (y1),
    .y2          (y2),
    .stall       (stall),
`ifdef VDP1_ERASE_ABORT_EN
    .abort       (abort),
`endif
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_wren     (fb_wren),
    .busy        (busy),
    .done        (done)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  logic stall_at_edge = 1'b0;
  logic [32:0] sb_q[$];
  int wr_count = 0, first_wr_cyc = -1, last_wr_cyc = -1;
  int done_count = 0, done_cyc = -1, n_start = 0;

  always @(posedge clock) begin
    cyc           <= cyc + 1;
    stall_at_edge <= stall;
  end

  // Write monitor: every write must match the head of the scoreboard.
  always @(negedge clock) begin
    logic [32:0] exp_w;
    if (fb_wren === 2'b11) begin
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      wr_count++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected addr=%0d data=%h required=no write", fb_addr, fb_data);
      end else begin
        exp_w = sb_q.pop_front();
        if ({fb_addr, fb_data} !== exp_w) begin
          errors++;
          $display("FAIL write_data addr=%0d data=%h required addr=%0d data=%h",
                   fb_addr, fb_data, exp_w[32:16], exp_w[15:0]);
        end
      end
    end else if (fb_wren !== 2'b00) begin
      checks++;
      errors++;
      $display("FAIL wren_value got=%b required=00 or 11", fb_wren);
    end
    if (stall_at_edge) begin
      checks++;
      if (fb_wren !== 2'b00) begin
        errors++;
        $display("FAIL stalled_write wren=%b required=00", fb_wren);
      end
    end
    if (done === 1'b1) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_stats();
    wr_count = 0; first_wr_cyc = -1; last_wr_cyc = -1; done_count = 0; done_cyc = -1;
  endtask

  task automatic push_rect(input int xa, input int xb, input int ya, input int yb,
                           input logic [15:0] col);
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++)
        sb_q.push_back({17'(y * 352 + x), col});
  endtask

  task automatic kick(input int a, input int b, input int c, input int d,
                      input logic [15:0] col);
    clear_stats();
    tick();
    x1 = 6'(a); x2 = 6'(b); y1 = 9'(c); y2 = 9'(d); erase_color = col;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_start = cyc;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_count == 0 && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks += 5;
    if (fb_addr !== '0) begin errors++; $display("FAIL reset_addr got=%0d required=0", fb_addr); end
    if (fb_data !== '0) begin errors++; $display("FAIL reset_data got=%h required=0", fb_data); end
    if (fb_wren !== '0) begin errors++; $display("FAIL reset_wren got=%b required=00", fb_wren); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b required=0", done); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_block();
    push_rect(16, 23, 5, 5, 16'h8000);
    kick(2, 2, 5, 5, 16'h8000);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b required=1", busy); end
    wait_done(40);
    checks += 4;
    if (wr_count != 8) begin errors++; $display("FAIL single_count got=%0d required=8", wr_count); end
    if (first_wr_cyc != n_start + 2) begin
      errors++; $display("FAIL single_first got=%0d required=%0d", first_wr_cyc, n_start + 2);
    end
    if (done_cyc != n_start + 10) begin
      errors++; $display("FAIL single_done got=%0d required=%0d", done_cyc, n_start + 10);
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b required=0", busy); end
    tick();
  endtask

  task automatic test_clip();
    push_rect(320, 351, 250, 255, 16'h1234);
    kick(40, 50, 250, 300, 16'h1234);
    wait_done(400);
    checks += 2;
    if (wr_count != 192) begin errors++; $display("FAIL clip_count got=%0d required=192", wr_count); end
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL clip_left got=%0d required=0", sb_q.size());
    end
    tick();
  endtask

  task automatic test_stall();
    push_rect(0, 7, 0, 1, 16'hbeef);
    kick(0, 0, 0, 1, 16'hbeef);
    for (int i = 0; i < 80 && done_count == 0; i++) begin
      stall = ~stall;
      tick();
    end
    stall = 1'b0;
    checks += 3;
    if (done_count != 1) begin errors++; $display("FAIL stall_done got=%0d required=1", done_count); end
    if (wr_count != 16) begin errors++; $display("FAIL stall_count got=%0d required=16", wr_count); end
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL stall_left got=%0d required=0", sb_q.size());
    end
    tick();
  endtask

  task automatic test_empty();
    kick(5, 4, 0, 0, 16'hffff);
    wait_done(10);
    checks += 2;
    if (done_cyc != n_start + 2) begin
      errors++; $display("FAIL empty_done got=%0d required=%0d", done_cyc, n_start + 2);
    end
    if (wr_count != 0) begin errors++; $display("FAIL empty_count got=%0d required=0", wr_count); end
    tick();
  endtask

  task automatic test_start_ignored();
    push_rect(8, 15, 3, 3, 16'h0f0f);
    kick(1, 1, 3, 3, 16'h0f0f);
    tick();
    x1 = 6'd0; x2 = 6'd43; y1 = 9'd0; y2 = 9'd255; erase_color = 16'h5555;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40);
    repeat (6) tick();
    checks += 3;
    if (wr_count != 8) begin errors++; $display("FAIL busy_start_count got=%0d required=8", wr_count); end
    if (done_count != 1) begin
      errors++; $display("FAIL busy_start_done got=%0d required=1", done_count);
    end
    if (done_cyc != n_start + 10) begin
      errors++; $display("FAIL busy_start_time got=%0d required=%0d", done_cyc, n_start + 10);
    end
  endtask

  task automatic test_reset_mid();
    int saved;
    push_rect(0, 351, 0, 1, 16'h7777);
    kick(0, 43, 0, 1, 16'h7777);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    checks += 2;
    if (fb_wren !== 2'b00) begin errors++; $display("FAIL rst_mid_wren got=%b required=00", fb_wren); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b required=0", busy); end
    reset = 1'b0;
    sb_q.delete();
    saved = wr_count;
    repeat (5) tick();
    checks++;
    if (wr_count != saved) begin
      errors++; $display("FAIL rst_mid_quiet got=%0d required=%0d", wr_count, saved);
    end
  endtask

  task automatic test_full_screen();
    push_rect(0, 351, 0, 255, 16'ha5a5);
    kick(0, 43, 0, 255, 16'ha5a5);
    wait_done(90200);
    checks += 4;
    if (wr_count != 90112) begin
      errors++; $display("FAIL full_count got=%0d required=90112", wr_count);
    end
    if (last_wr_cyc != n_start + 1 + 90112) begin
      errors++; $display("FAIL full_last got=%0d required=%0d", last_wr_cyc, n_start + 90113);
    end
    if (done_cyc != last_wr_cyc + 1) begin
      errors++; $display("FAIL full_done got=%0d required=%0d", done_cyc, last_wr_cyc + 1);
    end
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL full_left got=%0d required=0", sb_q.size());
    end
    tick();
  endtask

`ifdef VDP1_ERASE_ABORT_EN
  task automatic test_abort();
    int ab_cyc;
    push_rect(0, 9, 0, 0, 16'hc0de);
    kick(0, 43, 0, 255, 16'hc0de);
    for (int i = 0; i < 50 && wr_count < 10; i++) tick();
    abort = 1'b1;
    ab_cyc = cyc;
    tick();
    abort = 1'b0;
    wait_done(10);
    repeat (3) tick();
    checks += 2;
    if (wr_count != 10) begin errors++; $display("FAIL abort_count got=%0d required=10", wr_count); end
    if (done_cyc != ab_cyc + 2) begin
      errors++; $display("FAIL abort_done got=%0d required=%0d", done_cyc, ab_cyc + 2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_block();
    test_clip();
    test_stall();
    test_empty();
    test_start_ignored();
    test_reset_mid();
    test_full_screen();
`ifdef VDP1_ERASE_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
